// File: rtl/rtc_set_arbiter_pkg.sv
// Shared types and limits for the RTC time-set arbiter.
// Package rtc_pkg: BCD time/field types, range limits and arbiter FSM states.
package rtc_pkg;

    // {hh[21:16], mm[15:8], ss[7:0]} in packed BCD
    typedef logic [21:0] bcd_time_t;

    // Field enables {hh, mm, ss}
    typedef logic [2:0]  field_valid_t;

    localparam logic [7:0]   SS_MAX    = 8'h59;
    localparam logic [7:0]   MM_MAX    = 8'h59;
    localparam logic [5:0]   HH_MAX    = 6'h23;
    localparam field_valid_t VALID_ALL = 3'b111;

    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rtc_set_arbiter_bcd_check.sv
// rtc_bcd_check: combinational BCD range check of an hh:mm:ss time.
// Only fields whose enable bit is set are checked; an all-zero enable fails.
module rtc_bcd_check
    import rtc_pkg::*;
(
    input  bcd_time_t    i_time,
    input  field_valid_t i_valid,
    output logic         o_ok
);

    logic w_ss_ok;
    logic w_mm_ok;
    logic w_hh_ok;

    // Per-field digit range checks, then combine with the field enables
    always_comb begin
        w_ss_ok = (i_time[3:0]   <= 4'h9) && (i_time[7:4]   <= SS_MAX[7:4]);
        w_mm_ok = (i_time[11:8]  <= 4'h9) && (i_time[15:12] <= MM_MAX[7:4]);
        w_hh_ok = (i_time[19:16] <= 4'h9) && (i_time[21:16] <= HH_MAX);
        o_ok    = (i_valid != 3'b000)
                  && (!i_valid[0] || w_ss_ok)
                  && (!i_valid[1] || w_mm_ok)
                  && (!i_valid[2] || w_hh_ok);
    end

endmodule

// File: rtl/rtc_set_arbiter.sv
// rtc_set_arbiter: shares the RTC time-set port between the host and GPS sync.
// Host writes go out one clock after the request is sampled; GPS times are held
// and written on the next PPS so they land on a second boundary.
// Optional feature macro: RTCARB_TIMEOUT_EN (GPS wait-for-PPS timeout).
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | no GPS time held; host requests served directly
//   ARMED | GPS time held, waiting for PPS; host served on non-PPS clocks
module rtc_set_arbiter
   import rtc_pkg::*;
#(
   parameter int                    LGTIMEOUT    = 27,
   parameter logic [LGTIMEOUT-1:0]  TIMEOUT_CLKS = 27'd100_000_000
)
(
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic          i_pps,
   input  logic          i_host_req,
   input  bcd_time_t     i_host_data,
   input  field_valid_t  i_host_valid,
   output logic          o_host_ack,
   output logic          o_host_err,
   input  logic          i_gps_req,
   input  bcd_time_t     i_gps_data,
   output logic          o_gps_ack,
   output logic          o_gps_err,
   output logic          o_wr,
   output bcd_time_t     o_data,
   output field_valid_t  o_valid,
   output logic          o_gps_pending
);

   arb_state_t   r_state, w_state_nxt;
   bcd_time_t    r_hold, w_hold_nxt;
   logic         r_wr, w_wr_nxt;
   bcd_time_t    r_data, w_data_nxt;
   field_valid_t r_valid, w_valid_nxt;
   logic         r_host_ack, w_host_ack_nxt;
   logic         r_host_err, w_host_err_nxt;
   logic         r_gps_ack, w_gps_ack_nxt;
   logic         r_gps_err, w_gps_err_nxt;
   logic         r_pending;

   logic         w_host_ok;
   logic         w_gps_ok;
   logic         w_host_take;
   logic         w_gps_take;
   logic         w_host_serve;

   rtc_bcd_check u_host_check (
      .i_time  (i_host_data),
      .i_valid (i_host_valid),
      .o_ok    (w_host_ok)
   );

   rtc_bcd_check u_gps_check (
      .i_time  (i_gps_data),
      .i_valid (VALID_ALL),
      .o_ok    (w_gps_ok)
   );

   // A request whose ack is on the outputs this clock has already been served;
   // masking it stops a still-held req from producing a second ack.
   assign w_host_take = i_host_req && !r_host_ack;
   assign w_gps_take  = i_gps_req  && !r_gps_ack;

`ifdef RTCARB_TIMEOUT_EN
   localparam logic [LGTIMEOUT-1:0] TC_LAST = TIMEOUT_CLKS - 1'b1;

   logic [LGTIMEOUT-1:0] r_cnt;

   // Clocks spent in ARMED; held at zero in IDLE so every ARMED entry starts fresh
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset)
         r_cnt <= '0;
      else if (r_state == IDLE)
         r_cnt <= '0;
      else
         r_cnt <= r_cnt + 1'b1;
   end
`endif

   // Next-state and next-output decode
   always_comb begin
      w_state_nxt    = r_state;
      w_hold_nxt     = r_hold;
      w_wr_nxt       = 1'b0;
      w_data_nxt     = '0;
      w_valid_nxt    = '0;
      w_host_ack_nxt = 1'b0;
      w_host_err_nxt = 1'b0;
      w_gps_ack_nxt  = 1'b0;
      w_gps_err_nxt  = 1'b0;
      w_host_serve   = 1'b0;

      case (r_state)
         IDLE: begin
            if (w_gps_take) begin
               if (w_gps_ok) begin
                  w_hold_nxt  = i_gps_data;
                  w_state_nxt = ARMED;
               end else begin
                  w_gps_ack_nxt = 1'b1;
                  w_gps_err_nxt = 1'b1;
               end
            end else begin
               w_host_serve = w_host_take;
            end
         end
         ARMED: begin
            if (!i_gps_req) begin
               // requester withdrew: abandon the held time quietly
               w_state_nxt  = IDLE;
               w_host_serve = w_host_take;
            end else if (i_pps) begin
               w_wr_nxt      = 1'b1;
               w_data_nxt    = r_hold;
               w_valid_nxt   = VALID_ALL;
               w_gps_ack_nxt = 1'b1;
               w_state_nxt   = IDLE;
            end else begin
`ifdef RTCARB_TIMEOUT_EN
               if (r_cnt == TC_LAST) begin
                  w_gps_ack_nxt = 1'b1;
                  w_gps_err_nxt = 1'b1;
                  w_state_nxt   = IDLE;
               end
`endif
               w_host_serve = w_host_take;
            end
         end
      endcase

      if (w_host_serve) begin
         w_host_ack_nxt = 1'b1;
         if (w_host_ok) begin
            w_wr_nxt    = 1'b1;
            w_data_nxt  = i_host_data;
            w_valid_nxt = i_host_valid;
         end else begin
            w_host_err_nxt = 1'b1;
         end
      end
   end

   // State, holding register and registered outputs
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state    <= IDLE;
         r_hold     <= '0;
         r_wr       <= 1'b0;
         r_data     <= '0;
         r_valid    <= '0;
         r_host_ack <= 1'b0;
         r_host_err <= 1'b0;
         r_gps_ack  <= 1'b0;
         r_gps_err  <= 1'b0;
         r_pending  <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_hold     <= w_hold_nxt;
         r_wr       <= w_wr_nxt;
         r_data     <= w_data_nxt;
         r_valid    <= w_valid_nxt;
         r_host_ack <= w_host_ack_nxt;
         r_host_err <= w_host_err_nxt;
         r_gps_ack  <= w_gps_ack_nxt;
         r_gps_err  <= w_gps_err_nxt;
         r_pending  <= (w_state_nxt == ARMED);
      end
   end

   assign o_wr          = r_wr;
   assign o_data        = r_data;
   assign o_valid       = r_valid;
   assign o_host_ack    = r_host_ack;
   assign o_host_err    = r_host_err;
   assign o_gps_ack     = r_gps_ack;
   assign o_gps_err     = r_gps_err;
   assign o_gps_pending = r_pending;

endmodule
